// File: rtl/rc4_decrypt_core.sv
// rtl/rc4_decrypt_core.sv - RC4 keystream generation and XOR decryption stage
//
// Purpose: after the key schedule has shuffled S memory, generate MSG_LEN RC4
// keystream bytes, XOR each with the encrypted ROM byte and write the result
// to decrypted memory. finish_Task2b is held until start_Task2b drops.
//
// Ports:
//   clk, reset (async, active-low)
//   start_Task2b / finish_Task2b     : level request / done handshake
//   S_* : S memory read/write port   (address, data out/in, readWrite, start/finish)
//   E_* : encrypted ROM read port    (address, data in, start/finish)
//   D_* : decrypted memory write port(address, data out, readWrite, start/finish)

module rc4_decrypt_core #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_Task2b,
  output logic       finish_Task2b,
  output logic [7:0] S_address,
  output logic [7:0] S_data_out,
  input  logic [7:0] S_data_in,
  output logic       S_readWrite,
  output logic       S_start_readWrite_op,
  input  logic       S_finish_readWrite_op,
  output logic [7:0] E_address,
  input  logic [7:0] E_data_in,
  output logic       E_start_readWrite_op,
  input  logic       E_finish_readWrite_op,
  output logic [7:0] D_address,
  output logic [7:0] D_data_out,
  output logic       D_readWrite,
  output logic       D_start_readWrite_op,
  input  logic       D_finish_readWrite_op
);

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INC_I,
    ST_RD_SI_ISSUE, ST_RD_SI_WAIT,
    ST_RD_SJ_ISSUE, ST_RD_SJ_WAIT,
    ST_WR_SI_ISSUE, ST_WR_SI_WAIT,
    ST_WR_SJ_ISSUE, ST_WR_SJ_WAIT,
    ST_RD_F_ISSUE,  ST_RD_F_WAIT,
    ST_RD_E_ISSUE,  ST_RD_E_WAIT,
    ST_WR_D_ISSUE,  ST_WR_D_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [7:0] LP_LAST_K = 8'(MSG_LEN - 1);

  state_t     r_state;
  logic [7:0] r_i, r_j, r_k, r_si, r_sj, r_f;

  logic [7:0] w_i_next;
  logic [7:0] w_j_next;
  logic [7:0] w_f_addr;
  logic [7:0] w_d_data;

  assign w_i_next = r_i + 8'd1;
  // j uses the S[i] value arriving this cycle, so RD_SJ can address S[j] at once
  assign w_j_next = r_j + S_data_in;
  assign w_f_addr = r_si + r_sj;
  assign w_d_data = r_f ^ E_data_in;

  // Every memory request is launched on the edge that enters its ISSUE state,
  // so the start strobe and address are registered and stable for the whole
  // ISSUE + WAIT window. Start strobes default low to make them single-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state              <= ST_IDLE;
      r_i                  <= 8'd0;
      r_j                  <= 8'd0;
      r_k                  <= 8'd0;
      r_si                 <= 8'd0;
      r_sj                 <= 8'd0;
      r_f                  <= 8'd0;
      finish_Task2b        <= 1'b0;
      S_address            <= 8'd0;
      S_data_out           <= 8'd0;
      S_readWrite          <= 1'b0;
      S_start_readWrite_op <= 1'b0;
      E_address            <= 8'd0;
      E_start_readWrite_op <= 1'b0;
      D_address            <= 8'd0;
      D_data_out           <= 8'd0;
      D_readWrite          <= 1'b0;
      D_start_readWrite_op <= 1'b0;
    end else begin
      S_start_readWrite_op <= 1'b0;
      E_start_readWrite_op <= 1'b0;
      D_start_readWrite_op <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start_Task2b) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= 8'd0;
            r_state <= ST_INC_I;
          end
        end

        ST_INC_I: begin
          r_i                  <= w_i_next;
          S_address            <= w_i_next;
          S_data_out           <= 8'd0;
          S_readWrite          <= 1'b0;
          S_start_readWrite_op <= 1'b1;
          r_state              <= ST_RD_SI_ISSUE;
        end

        ST_RD_SI_ISSUE: r_state <= ST_RD_SI_WAIT;
        ST_RD_SI_WAIT: begin
          if (S_finish_readWrite_op) begin
            r_si                 <= S_data_in;
            r_j                  <= w_j_next;
            S_address            <= w_j_next;
            S_start_readWrite_op <= 1'b1;
            r_state              <= ST_RD_SJ_ISSUE;
          end
        end

        ST_RD_SJ_ISSUE: r_state <= ST_RD_SJ_WAIT;
        ST_RD_SJ_WAIT: begin
          if (S_finish_readWrite_op) begin
            r_sj                 <= S_data_in;
            S_address            <= r_i;
            S_data_out           <= S_data_in;
            S_readWrite          <= 1'b1;
            S_start_readWrite_op <= 1'b1;
            r_state              <= ST_WR_SI_ISSUE;
          end
        end

        ST_WR_SI_ISSUE: r_state <= ST_WR_SI_WAIT;
        ST_WR_SI_WAIT: begin
          if (S_finish_readWrite_op) begin
            S_address            <= r_j;
            S_data_out           <= r_si;
            S_start_readWrite_op <= 1'b1;
            r_state              <= ST_WR_SJ_ISSUE;
          end
        end

        ST_WR_SJ_ISSUE: r_state <= ST_WR_SJ_WAIT;
        ST_WR_SJ_WAIT: begin
          if (S_finish_readWrite_op) begin
            S_address            <= w_f_addr;
            S_data_out           <= 8'd0;
            S_readWrite          <= 1'b0;
            S_start_readWrite_op <= 1'b1;
            r_state              <= ST_RD_F_ISSUE;
          end
        end

        ST_RD_F_ISSUE: r_state <= ST_RD_F_WAIT;
        ST_RD_F_WAIT: begin
          if (S_finish_readWrite_op) begin
            r_f                  <= S_data_in;
            S_address            <= 8'd0;
            E_address            <= r_k;
            E_start_readWrite_op <= 1'b1;
            r_state              <= ST_RD_E_ISSUE;
          end
        end

        ST_RD_E_ISSUE: r_state <= ST_RD_E_WAIT;
        ST_RD_E_WAIT: begin
          if (E_finish_readWrite_op) begin
            E_address            <= 8'd0;
            D_address            <= r_k;
            D_data_out           <= w_d_data;
            D_readWrite          <= 1'b1;
            D_start_readWrite_op <= 1'b1;
            r_state              <= ST_WR_D_ISSUE;
          end
        end

        ST_WR_D_ISSUE: r_state <= ST_WR_D_WAIT;
        ST_WR_D_WAIT: begin
          if (D_finish_readWrite_op) begin
            D_address   <= 8'd0;
            D_data_out  <= 8'd0;
            D_readWrite <= 1'b0;
            r_state     <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          if (r_k == LP_LAST_K) begin
            finish_Task2b <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= ST_INC_I;
          end
        end

        // A held-high start must not retrigger, so wait for it to drop first
        ST_DONE: begin
          if (!start_Task2b) begin
            finish_Task2b <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// tb/tb_rc4_decrypt_core.sv - directed bench for rc4_decrypt_core

module tb_rc4_decrypt_core;

  localparam int MSG = 32;

  logic       clk;
  logic       reset;
  logic       start_Task2b;
  logic       finish_Task2b;
  logic [7:0] S_address, S_data_out, S_data_in;
  logic       S_readWrite, S_start_readWrite_op, S_finish_readWrite_op;
  logic [7:0] E_address, E_data_in;
  logic       E_start_readWrite_op, E_finish_readWrite_op;
  logic [7:0] D_address, D_data_out;
  logic       D_readWrite, D_start_readWrite_op, D_finish_readWrite_op;

  rc4_decrypt_core #(.MSG_LEN(MSG)) dut (
    .clk(clk), .reset(reset),
    .start_Task2b(start_Task2b), .finish_Task2b(finish_Task2b),
    .S_address(S_address), .S_data_out(S_data_out), .S_data_in(S_data_in),
    .S_readWrite(S_readWrite), .S_start_readWrite_op(S_start_readWrite_op),
    .S_finish_readWrite_op(S_finish_readWrite_op),
    .E_address(E_address), .E_data_in(E_data_in),
    .E_start_readWrite_op(E_start_readWrite_op),
    .E_finish_readWrite_op(E_finish_readWrite_op),
    .D_address(D_address), .D_data_out(D_data_out), .D_readWrite(D_readWrite),
    .D_start_readWrite_op(D_start_readWrite_op),
    .D_finish_readWrite_op(D_finish_readWrite_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory models
  logic [7:0] S_mem [256];
  logic [7:0] E_mem [256];
  logic [7:0] D_mem [256];
  logic [7:0] exp_d [256];
  logic [7:0] exp_s [256];
  logic [7:0] rd_log [64];

  int lat_fixed = 1;
  bit lat_rand  = 0;
  int stray_cnt = 0;
  int s_cnt = 0, e_cnt = 0, d_cnt = 0;
  logic [7:0] s_addr, s_wd, e_addr, d_addr, d_wd;
  logic       s_rw;
  int n_starts = 0, n_writes = 0, n_swr = 0, n_srd = 0;
  int n_multi = 0, n_unstable = 0, n_bad_drw = 0;
  logic [7:0] snap2, snap3, snap5;

  function automatic int lat();
    return lat_rand ? int'($urandom_range(1, 5)) : lat_fixed;
  endfunction

  function automatic logic [63:0] all_outs();
    return {18'd0, finish_Task2b, S_address, S_data_out, S_readWrite, S_start_readWrite_op,
            E_address, E_start_readWrite_op, D_address, D_data_out, D_readWrite,
            D_start_readWrite_op};
  endfunction

  // Responses change on the falling edge so the DUT sees them stable at posedge
  always @(negedge clk) begin
    S_finish_readWrite_op = 1'b0;
    E_finish_readWrite_op = 1'b0;
    D_finish_readWrite_op = 1'b0;
    S_data_in = 8'h5A;
    E_data_in = 8'hA5;
    if (int'(S_start_readWrite_op) + int'(E_start_readWrite_op) + int'(D_start_readWrite_op) > 1)
      n_multi++;
    if (!reset) begin
      s_cnt = 0; e_cnt = 0; d_cnt = 0; stray_cnt = 0;
    end else begin
      if (stray_cnt > 0) begin
        D_finish_readWrite_op = 1'b1;
        stray_cnt--;
      end
      if (s_cnt != 0) begin
        if (S_address != s_addr || S_readWrite != s_rw || S_data_out != s_wd) n_unstable++;
        s_cnt--;
        if (s_cnt == 0) begin
          S_finish_readWrite_op = 1'b1;
          if (s_rw) begin S_mem[s_addr] = s_wd; n_writes++; end
          else S_data_in = S_mem[s_addr];
        end
      end
      if (e_cnt != 0) begin
        if (E_address != e_addr) n_unstable++;
        e_cnt--;
        if (e_cnt == 0) begin
          E_finish_readWrite_op = 1'b1;
          E_data_in = E_mem[e_addr];
        end
      end
      if (d_cnt != 0) begin
        if (D_address != d_addr || D_data_out != d_wd || !D_readWrite) n_unstable++;
        d_cnt--;
        if (d_cnt == 0) begin
          D_finish_readWrite_op = 1'b1;
          D_mem[d_addr] = d_wd;
          n_writes++;
        end
      end
      if (S_start_readWrite_op) begin
        n_starts++;
        s_cnt = lat(); s_addr = S_address; s_rw = S_readWrite; s_wd = S_data_out;
        if (s_rw) n_swr++;
        else begin
          if (n_srd < 64) rd_log[n_srd] = S_address;
          n_srd++;
        end
      end
      if (E_start_readWrite_op) begin
        n_starts++;
        e_cnt = lat(); e_addr = E_address;
      end
      if (D_start_readWrite_op) begin
        n_starts++;
        d_cnt = lat(); d_addr = D_address; d_wd = D_data_out;
        if (!D_readWrite) n_bad_drw++;
        if (D_address == 8'd2) begin
          snap2 = S_mem[2]; snap3 = S_mem[3]; snap5 = S_mem[5];
        end
      end
    end
  end

  task automatic s_identity();
    for (int n = 0; n < 256; n++) begin
      S_mem[n] = 8'(n); E_mem[n] = 8'h00; D_mem[n] = 8'h00;
    end
  endtask

  // Reference RC4 PRGA over the current contents of the memory models
  task automatic golden();
    logic [7:0] gs [256];
    logic [7:0] gi, gj, t;
    for (int n = 0; n < 256; n++) gs[n] = S_mem[n];
    gi = 0; gj = 0;
    for (int n = 0; n < MSG; n++) begin
      gi = gi + 8'd1;
      gj = gj + gs[gi];
      t = gs[gi]; gs[gi] = gs[gj]; gs[gj] = t;
      t = gs[gi] + gs[gj];
      exp_d[n] = gs[t] ^ E_mem[n];
    end
    for (int n = 0; n < 256; n++) exp_s[n] = gs[n];
  endtask

  task automatic compare_mem(input string tag);
    int bad_d = 0;
    int bad_s = 0;
    for (int n = 0; n < MSG; n++) if (D_mem[n] !== exp_d[n]) bad_d++;
    for (int n = 0; n < 256; n++) if (S_mem[n] !== exp_s[n]) bad_s++;
    check({tag, "_d_bytes_wrong"}, 64'(bad_d), 64'd0);
    check({tag, "_s_bytes_wrong"}, 64'(bad_s), 64'd0);
  endtask

  // Raise start, count posedges from the start edge until finish is seen
  task automatic do_run(input int stray, output int cycles);
    @(negedge clk);
    n_srd = 0;
    start_Task2b = 1'b1;
    stray_cnt = stray;
    @(posedge clk);
    cycles = 0;
    while (cycles < 20000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (finish_Task2b) break;
    end
    check("run_finished", 64'(finish_Task2b), 64'd1);
  endtask

  task automatic end_run();
    @(negedge clk);
    start_Task2b = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("finish_dropped", 64'(finish_Task2b), 64'd0);
  endtask

  int cyc;
  int base;

  initial begin
    reset = 1'b0;
    start_Task2b = 1'b0;
    S_data_in = 8'h0; E_data_in = 8'h0;
    S_finish_readWrite_op = 1'b0; E_finish_readWrite_op = 1'b0; D_finish_readWrite_op = 1'b0;
    s_identity();
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Identity S, zero ciphertext, latency 1
    s_identity();
    golden();
    lat_fixed = 1; lat_rand = 0;
    do_run(0, cyc);
    check("cycles_to_finish", 64'(cyc), 64'd512);
    check("id_D0", 64'(D_mem[0]), 64'h02);
    check("id_D1", 64'(D_mem[1]), 64'h05);
    check("id_D2", 64'(D_mem[2]), 64'h07);
    check("id_S2_after_byte2", 64'(snap2), 64'd3);
    check("id_S3_after_byte2", 64'(snap3), 64'd5);
    check("id_S5_after_byte2", 64'(snap5), 64'd2);
    compare_mem("identity");
    end_run();

    // Known ciphertext bytes
    s_identity();
    E_mem[0] = 8'hD0; E_mem[1] = 8'h6B;
    do_run(0, cyc);
    check("ct_D0", 64'(D_mem[0]), 64'hD2);
    check("ct_D1", 64'(D_mem[1]), 64'h6E);
    end_run();

    // Random permutation, random ciphertext, random latency, start held high
    for (int n = 0; n < 256; n++) begin
      S_mem[n] = 8'(n); E_mem[n] = 8'($urandom); D_mem[n] = 8'h00;
    end
    for (int n = 255; n > 0; n--) begin
      int r;
      logic [7:0] t;
      r = int'($urandom_range(0, n));
      t = S_mem[n]; S_mem[n] = S_mem[r]; S_mem[r] = t;
    end
    golden();
    lat_rand = 1;
    do_run(0, cyc);
    compare_mem("random_lat");
    base = n_starts;
    repeat (40) @(negedge clk);
    #1 check("held_start_finish", 64'(finish_Task2b), 64'd1);
    check("held_start_no_new_ops", 64'(n_starts - base), 64'd0);
    end_run();
    for (int n = 0; n < 256; n++) D_mem[n] = 8'h00;
    golden();
    do_run(0, cyc);
    compare_mem("second_run");
    end_run();
    check("addr_stable_in_wait", 64'(n_unstable), 64'd0);
    check("single_start", 64'(n_multi), 64'd0);
    check("d_readwrite_high", 64'(n_bad_drw), 64'd0);

    // j wrap and RD_F address wrap, stray D finish pulses early in the byte
    lat_rand = 0; lat_fixed = 3;
    s_identity();
    S_mem[1] = 8'hFF; S_mem[8'hFF] = 8'h02;
    golden();
    do_run(6, cyc);
    check("wrap_rd_si_addr", 64'(rd_log[0]), 64'h01);
    check("wrap_rd_sj_addr", 64'(rd_log[1]), 64'hFF);
    check("wrap_rd_f_addr", 64'(rd_log[2]), 64'h01);
    check("wrap_D0", 64'(D_mem[0]), 64'h02);
    compare_mem("wrap_stray");
    end_run();

    // Reset during the WR_SJ wait of byte k=4 (tenth S write)
    s_identity();
    base = n_swr;
    @(negedge clk);
    start_Task2b = 1'b1;
    cyc = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      #1;
      if (n_swr >= base + 10) break;
    end
    check("reached_wr_sj_byte4", 64'(n_swr - base), 64'd10);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("mid_reset_outputs", all_outs(), 64'd0);
    base = n_writes;
    cyc = n_starts;
    start_Task2b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    #1 check("post_reset_no_writes", 64'(n_writes - base), 64'd0);
    check("post_reset_no_starts", 64'(n_starts - cyc), 64'd0);
    check("post_reset_idle_outs", all_outs(), 64'd0);
    check("post_reset_D4_unwritten", 64'(D_mem[4]), 64'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
